// File: rtl/conv_stream_kxk.sv
// rtl/conv_stream_kxk.sv - streaming KxK fixed-point 2-D convolution engine
//
// Pixels arrive one per in_valid/in_ready handshake in raster order. The
// previous KSIZE-1 rows sit in line buffers; every accepted pixel that
// completes a full KxK window (no padding) loads one rounded, saturated
// result into the output register, drained through out_valid/out_ready.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rows, cols        image size, sampled on an accepted start
//   start             begin a frame (honoured only in IDLE)
//   k_we/k_addr/k_data  coefficient write, index r*KSIZE+c (IDLE only)
//   in_valid/in_ready/in_data     input pixel stream
//   out_valid/out_ready/out_data  output pixel stream
//   busy              high while a frame is running
//   done              one-cycle pulse after the last output is accepted
//   cfg_err           one-cycle pulse when start carries an invalid size
//
// Build option: CONV_RELU_EN clamps negative results to zero.
module conv_stream_kxk #(
  parameter int TOTAL_BITS = 16,
  parameter int FRAC_BITS  = 8,
  parameter int KSIZE      = 3,
  parameter int MAX_COLS   = 64,
  parameter int MAX_ROWS   = 64,
  localparam int DW  = $clog2((MAX_ROWS > MAX_COLS) ? MAX_ROWS + 1 : MAX_COLS + 1),
  localparam int KAW = $clog2(KSIZE * KSIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         rows,
  input  logic [DW-1:0]         cols,
  input  logic                  start,
  input  logic                  k_we,
  input  logic [KAW-1:0]        k_addr,
  input  logic [TOTAL_BITS-1:0] k_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int KK  = KSIZE * KSIZE;
  localparam int PW  = 2 * TOTAL_BITS;
  localparam int AW  = PW + $clog2(KK) + 1;
  localparam int CW  = 2 * DW;
  localparam int CAW = $clog2(MAX_COLS);

  localparam logic [DW-1:0] K_DW = DW'(KSIZE);
  localparam logic [DW-1:0] KM1  = DW'(KSIZE - 1);

  localparam logic signed [AW-1:0] RND     = AW'(1) << (FRAC_BITS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-TOTAL_BITS+1){1'b0}}, {(TOTAL_BITS-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-TOTAL_BITS+1){1'b1}}, {(TOTAL_BITS-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [DW-1:0] rows_r, cols_r, row_i, col_i;
  logic [CW-1:0] out_total, out_cnt;
  logic          pixels_left;

  logic signed [TOTAL_BITS-1:0] kern    [KK];
  logic signed [TOTAL_BITS-1:0] win     [KSIZE][KSIZE];
  logic signed [TOTAL_BITS-1:0] nwin    [KSIZE][KSIZE];
  logic signed [TOTAL_BITS-1:0] col_vec [KSIZE];
  logic signed [TOTAL_BITS-1:0] lb      [KSIZE-1][MAX_COLS];

  logic [CAW-1:0] col_a;
  logic           cfg_ok, in_fire, out_fire, last_pix, last_out, win_done;

  logic signed [PW-1:0]         prod;
  logic signed [AW-1:0]         acc, rnd, shr;
  logic signed [TOTAL_BITS-1:0] res;

  assign cfg_ok = (rows >= K_DW) && (rows <= DW'(MAX_ROWS)) &&
                  (cols >= K_DW) && (cols <= DW'(MAX_COLS));

  // Combinational from out_ready so a draining output never costs a bubble.
  assign in_ready = (state == RUN) && pixels_left && (!out_valid || out_ready);
  assign busy     = (state == RUN);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign col_a    = col_i[CAW-1:0];
  assign last_pix = (row_i == rows_r - DW'(1)) && (col_i == cols_r - DW'(1));
  assign last_out = (out_cnt == out_total - CW'(1));
  // Gating on col_i keeps columns left over from the previous row out of any result.
  assign win_done = (row_i >= KM1) && (col_i >= KM1);

  // Window as it will look after the incoming pixel: shift left, new column on the right.
  // Row 0 is the oldest image row, row KSIZE-1 is the row currently streaming in.
  always_comb begin
    for (int r = 0; r < KSIZE - 1; r++) begin
      col_vec[r] = lb[KSIZE-2-r][col_a];
    end
    col_vec[KSIZE-1] = in_data;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        nwin[r][c] = win[r][c+1];
      end
      nwin[r][KSIZE-1] = col_vec[r];
    end
  end

  // Exact multiply-accumulate, round half up, arithmetic shift, saturate.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        prod = kern[r*KSIZE+c] * nwin[r][c];
        acc  = acc + {{(AW-PW){prod[PW-1]}}, prod};
      end
    end
    rnd = acc + RND;
    shr = rnd >>> FRAC_BITS;
    if (shr > SAT_MAX) begin
      res = {1'b0, {(TOTAL_BITS-1){1'b1}}};
    end else if (shr < SAT_MIN) begin
      res = {1'b1, {(TOTAL_BITS-1){1'b0}}};
    end else begin
      res = shr[TOTAL_BITS-1:0];
    end
`ifdef CONV_RELU_EN
    if (res[TOTAL_BITS-1]) begin
      res = '0;
    end
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && cfg_ok)        state_nx = RUN;
      RUN:  if (out_fire && last_out)   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_r      <= '0;
      cols_r      <= '0;
      row_i       <= '0;
      col_i       <= '0;
      out_total   <= '0;
      out_cnt     <= '0;
      pixels_left <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (cfg_ok) begin
            rows_r      <= rows;
            cols_r      <= cols;
            row_i       <= '0;
            col_i       <= '0;
            out_cnt     <= '0;
            out_total   <= CW'(rows - KM1) * CW'(cols - KM1);
            pixels_left <= 1'b1;
          end else begin
            cfg_err <= 1'b1;
          end
        end
      end else begin
        if (in_fire) begin
          if (col_i == cols_r - DW'(1)) begin
            col_i <= '0;
            row_i <= row_i + DW'(1);
          end else begin
            col_i <= col_i + DW'(1);
          end
          if (last_pix) begin
            pixels_left <= 1'b0;
          end
        end
        // A load can only happen when the register is empty or draining this cycle.
        if (in_fire && win_done) begin
          out_valid <= 1'b1;
          out_data  <= res;
        end else if (out_fire) begin
          out_valid <= 1'b0;
        end
        if (out_fire) begin
          if (last_out) begin
            done    <= 1'b1;
            out_cnt <= '0;
          end else begin
            out_cnt <= out_cnt + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KK; i++) begin
        kern[i] <= '0;
      end
    end else if (state == IDLE && k_we && (k_addr < KAW'(KK))) begin
      kern[k_addr] <= k_data;
    end
  end

  // Window and line buffers hold no state that matters across frames.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          win[r][c] <= nwin[r][c];
        end
      end
      lb[0][col_a] <= in_data;
      for (int j = 1; j < KSIZE - 1; j++) begin
        lb[j][col_a] <= lb[j-1][col_a];
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_kxk.sv
// tb/tb_conv_stream_kxk.sv - self-checking bench for conv_stream_kxk
module tb_conv_stream_kxk;

  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rows, cols;
  logic          start, k_we;
  logic [3:0]    k_addr;
  logic [15:0]   k_data;
  logic          in_valid, in_ready;
  logic [15:0]   in_data;
  logic          out_valid, out_ready;
  logic [15:0]   out_data;
  logic          busy, done, cfg_err;

  conv_stream_kxk dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .start(start),
    .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rows;
    int          cols;
    int          kall;
    logic [15:0] kval;
    int          ramp;
    logic [15:0] pval;
    int          inject;
    int          nexp;
    logic [5:0][15:0] exp;
  } vec_t;

  localparam int NV = 6;
  vec_t        vt [NV];
  logic [15:0] pix  [64];
  logic [15:0] outs [16];
  int          checks = 0;
  int          errors = 0;
  int          nout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int r, input int c, input int kall, input logic [15:0] kv,
                              input int ramp, input logic [15:0] pv, input int inj, input int n,
                              input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                              input logic [15:0] e3, input logic [15:0] e4, input logic [15:0] e5);
    vec_t v;
    v.rows = r; v.cols = c; v.kall = kall; v.kval = kv; v.ramp = ramp; v.pval = pv;
    v.inject = inj; v.nexp = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4; v.exp[5] = e5;
    return v;
  endfunction

  task automatic set_kernel(input int kall, input logic [15:0] kv);
    for (int i = 0; i < 9; i++) begin
      k_we   = 1'b1;
      k_addr = 4'(i);
      k_data = (kall != 0 || i == 4) ? kv : 16'h0000;
      @(posedge clk); #1;
    end
    k_we = 1'b0;
  endtask

  task automatic fill(input int ramp, input logic [15:0] pv, input int n);
    for (int i = 0; i < n; i++) begin
      pix[i] = (ramp != 0) ? 16'(i * 256) : pv;
    end
  endtask

  task automatic run_frame(input int r, input int c, input int bp, input int inject, output int n_out);
    int          idx = 0;
    int          cyc = 0;
    int          n = r * c;
    logic        got_done = 1'b0;
    logic        stall_prev = 1'b0;
    logic        fire_in, fire_out;
    logic [15:0] held = '0;
    logic [15:0] od;
    n_out = 0;
    rows = DW'(r); cols = DW'(c); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", busy, 1);
    while (!got_done && cyc < 2000) begin
      in_valid  = (idx < n);
      in_data   = (idx < n) ? pix[idx] : 16'h0000;
      out_ready = (bp != 0) ? ((cyc % 2) == 0) : 1'b1;
      if (inject != 0 && cyc == 3) begin
        start = 1'b1; rows = 3; cols = 3;
        k_we = 1'b1; k_addr = 4'd4; k_data = 16'h0200;
      end
      #1;
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
      end
      if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      fire_in    = in_valid && in_ready;
      fire_out   = out_valid && out_ready;
      od         = out_data;
      @(posedge clk); #1;
      start = 1'b0; k_we = 1'b0;
      if (fire_in) idx++;
      if (fire_out) begin
        if (n_out < 16) outs[n_out] = od;
        n_out++;
      end
      if (done) got_done = 1'b1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("done_seen", got_done, 1);
    chk("busy_fall", busy, 0);
    if (bp == 0) chk("flow_cycles", cyc, n + 1);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
  endtask

  initial begin
    rst = 1'b1; rows = '0; cols = '0; start = 1'b0; k_we = 1'b0; k_addr = '0; k_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    vt[0] = mk(4, 4, 0, 16'h0100, 1, 16'h0000, 0, 4,
               16'h0500, 16'h0600, 16'h0900, 16'h0A00, 16'h0000, 16'h0000);
    vt[1] = mk(3, 3, 1, 16'h0100, 0, 16'h7F00, 0, 1,
               16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
`ifdef CONV_RELU_EN
    vt[2] = mk(3, 3, 1, 16'h0100, 0, 16'h8100, 0, 1,
               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
`else
    vt[2] = mk(3, 3, 1, 16'h0100, 0, 16'h8100, 0, 1,
               16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
`endif
    vt[3] = mk(3, 3, 0, 16'h0080, 0, 16'h0001, 0, 1,
               16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vt[4] = mk(3, 3, 0, 16'h0080, 0, 16'hFFFF, 0, 1,
               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vt[5] = mk(4, 5, 0, 16'h0100, 1, 16'h0000, 1, 6,
               16'h0600, 16'h0700, 16'h0800, 16'h0B00, 16'h0C00, 16'h0D00);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_cfg_err", cfg_err, 0);

    for (int e = 0; e < 3; e++) begin
      rows  = (e == 2) ? 7'd2 : 7'd5;
      cols  = (e == 0) ? 7'd2 : ((e == 1) ? 7'd65 : 7'd5);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("cfg%0d_err", e), cfg_err, 1);
      chk($sformatf("cfg%0d_busy", e), busy, 0);
      @(posedge clk); #1;
      chk($sformatf("cfg%0d_err_pulse", e), cfg_err, 0);
      chk($sformatf("cfg%0d_busy2", e), busy, 0);
    end

    for (int v = 0; v < NV; v++) begin
      set_kernel(vt[v].kall, vt[v].kval);
      fill(vt[v].ramp, vt[v].pval, vt[v].rows * vt[v].cols);
      run_frame(vt[v].rows, vt[v].cols, 0, vt[v].inject, nout);
      chk($sformatf("v%0d_count", v), nout, vt[v].nexp);
      for (int i = 0; i < vt[v].nexp; i++) begin
        chk($sformatf("v%0d_out%0d", v, i), outs[i], vt[v].exp[i]);
      end
    end

    set_kernel(1, 16'h0100);
    fill(0, 16'h0100, 25);
    run_frame(5, 5, 1, 0, nout);
    chk("bp_count", nout, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("bp_out%0d", i), outs[i], 16'h0900);

    set_kernel(0, 16'h0100);
    fill(1, 16'h0000, 16);
    rows = 4; cols = 4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = pix[i];
      #1;
      chk($sformatf("mid_in_ready%0d", i), in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill(1, 16'h0000, 9);
    run_frame(3, 3, 0, 0, nout);
    chk("post_rst_kclr_count", nout, 1);
    chk("post_rst_kclr_out", outs[0], 16'h0000);
    set_kernel(0, 16'h0100);
    run_frame(3, 3, 0, 0, nout);
    chk("post_rst_count", nout, 1);
    chk("post_rst_out", outs[0], 16'h0400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
